// File: rtl/rr_mux_sel_arbiter.sv
// rr_mux_sel_arbiter
// Round-robin requester/sequencer sitting in front of a 4:1 mux (mux4to1_ip).
// Four channels request the shared mux. The winner's index drives `sel`, is
// held for SETTLE_CYCLES so the mux output can settle, and then `mux_f` is
// captured. The captured data and its channel index are offered downstream
// through a valid/ready handshake.
//
// Optional build macro: RR_ARB_XFER_CNT_EN
//   When defined, an 8-bit wrapping counter of completed handshakes is
//   exported on port xfer_cnt.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | no transfer in flight; arbitrate whenever any req is set
// SETTLE  | sel/grant held while the mux output settles (counter runs down)
// SAMPLE  | capture mux_f into out_data on this edge, raise out_valid
// OUTPUT  | out_valid held until out_ready; re-arbitrate on the handshake edge

module rr_mux_sel_arbiter #(
    parameter int WIDTH         = 3,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] mux_f,
    output logic [1:0]       sel,
    output logic [3:0]       grant,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_ch,
    output logic             out_valid,
    input  logic             out_ready
`ifdef RR_ARB_XFER_CNT_EN
    ,
    output logic [7:0]       xfer_cnt
`endif
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] SAMPLE = 2'd2;
    localparam logic [1:0] OUTPUT = 2'd3;

    localparam logic [2:0] SETTLE_LOAD = 3'(SETTLE_CYCLES - 1);

    logic [1:0] state;
    logic [1:0] last;
    logic [2:0] settle_cnt;

    logic [1:0] scan_base;
    logic [1:0] scan_idx;
    logic [1:0] pick;
    logic       found;
    logic       handshake;

    assign handshake = out_valid && out_ready;

    // Round-robin pick. On the handshake edge `last` is being overwritten
    // with out_ch, so scan from out_ch directly to arbitrate in the same edge.
    always_comb begin
        scan_base = (state == OUTPUT) ? out_ch : last;
        scan_idx  = 2'd0;
        pick      = 2'd0;
        found     = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            scan_idx = scan_base + 2'(k);
            if (!found && req[scan_idx]) begin
                found = 1'b1;
                pick  = scan_idx;
            end
        end
    end

    // Sequencer FSM with grant/select, settle timer and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last       <= 2'd3;
            settle_cnt <= 3'd0;
            sel        <= 2'd0;
            grant      <= 4'd0;
            out_data   <= '0;
            out_ch     <= 2'd0;
            out_valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        sel        <= pick;
                        grant      <= 4'b0001 << pick;
                        settle_cnt <= SETTLE_LOAD;
                        state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == 3'd0) begin
                        state <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - 3'd1;
                    end
                end
                SAMPLE: begin
                    out_data  <= mux_f;
                    out_ch    <= sel;
                    out_valid <= 1'b1;
                    grant     <= 4'd0;
                    state     <= OUTPUT;
                end
                OUTPUT: begin
                    if (handshake) begin
                        out_valid <= 1'b0;
                        last      <= out_ch;
                        if (found) begin
                            sel        <= pick;
                            grant      <= 4'b0001 << pick;
                            settle_cnt <= SETTLE_LOAD;
                            state      <= SETTLE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RR_ARB_XFER_CNT_EN
    // Completed-handshake counter, wraps naturally at 8 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_cnt <= 8'd0;
        end else if (handshake) begin
            xfer_cnt <= xfer_cnt + 8'd1;
        end
    end
`endif

endmodule
